// File: rtl/mem_scan_loader_pkg.sv
// Shared types and constants for the memory-bank scan-chain loader.
// The chain is 31 data cells, the button bit and the 7-bit LED register (256 bits).
package mem_scan_pkg;

   localparam int SCAN_DATA_WIDTH = 8;
   localparam int SCAN_CHAIN_LEN  = 256;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      SHIFT,
      EMIT,
      FINISH
   } scan_state_e;

endpackage

// File: rtl/mem_scan_loader_scan_serdes.sv
// Byte serialiser/deserialiser for the scan chain.
// Sends MSB first and captures the bit leaving the chain before each shift.
module scan_serdes
   import mem_scan_pkg::*;
#(
   parameter int DATA_WIDTH = SCAN_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_shift,
   input  logic                  i_recirc,
   input  logic                  i_scan_out,
   output logic                  o_scan_in,
   output logic                  o_last_bit,
   output logic [DATA_WIDTH-1:0] o_rx_word
);

   localparam int BW = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] r_tx;
   logic [DATA_WIDTH-1:0] r_rx;
   logic [BW-1:0]         r_bit_cnt;
   logic                  w_tx_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx      <= '0;
         r_rx      <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (i_load) begin
            r_tx      <= i_tx_data;
            r_bit_cnt <= '0;
         end else if (i_shift) begin
            r_rx      <= o_rx_word;
            r_bit_cnt <= r_bit_cnt + BW'(1);
         end
      end
   end

   assign w_tx_bit   = r_tx[LAST_BIT - r_bit_cnt];
   // Recirculation feeds the outgoing bit straight back so a dump is non-destructive.
   assign o_scan_in  = i_recirc ? i_scan_out : w_tx_bit;
   assign o_last_bit = (r_bit_cnt == LAST_BIT);
   // Includes the bit being sampled this cycle, so the word is complete on the last shift.
   assign o_rx_word  = {r_rx[DATA_WIDTH-2:0], i_scan_out};

endmodule

// File: rtl/mem_scan_loader.sv
// Scan-chain pass controller: streams host bytes into the memory bank chain while
// returning the bytes that fall out, and holds the CPU while the chain moves.
module mem_scan_loader
   import mem_scan_pkg::*;
#(
   parameter int DATA_WIDTH = SCAN_DATA_WIDTH,
   parameter int CHAIN_LEN  = SCAN_CHAIN_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  recirculate,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  mem_scan_enable,
   output logic                  mem_scan_in,
   input  logic                  mem_scan_out,
   output logic                  cpu_halt,
   output logic                  busy,
   output logic                  done
);

   localparam int BYTE_CNT = CHAIN_LEN / DATA_WIDTH;
   localparam int BCW      = $clog2(BYTE_CNT) + 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTE_CNT - 1);

   scan_state_e           r_state;
   scan_state_e           w_state_next;
   logic                  r_mode;
   logic [BCW-1:0]        r_byte_cnt;
   logic [DATA_WIDTH-1:0] r_out_data;

   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_scan_en;
   logic                  w_busy;
   logic                  w_done;
   logic                  w_load;
   logic                  w_last_bit;
   logic                  w_serdes_in;
   logic [DATA_WIDTH-1:0] w_rx_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:   if (start) w_state_next = FETCH;
         FETCH: begin
            if (abort)                    w_state_next = IDLE;
            else if (r_mode || in_valid)  w_state_next = SHIFT;
         end
         SHIFT: begin
            if (abort)           w_state_next = IDLE;
            else if (w_last_bit) w_state_next = EMIT;
         end
         EMIT: begin
            if (abort)          w_state_next = IDLE;
            else if (out_ready) w_state_next = (r_byte_cnt == LAST_BYTE) ? FINISH : FETCH;
         end
         FINISH:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Abort masks every strobe in its cycle so no handshake or shift slips through.
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_scan_en   = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         FETCH: begin
            w_busy     = 1'b1;
            w_in_ready = !r_mode && !abort;
         end
         SHIFT: begin
            w_busy    = 1'b1;
            w_scan_en = !abort;
         end
         EMIT: begin
            w_busy      = 1'b1;
            w_out_valid = !abort;
         end
         FINISH:  w_done = !abort;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= 1'b0;
         r_byte_cnt <= '0;
         r_out_data <= '0;
      end else begin
         if (r_state == IDLE && start) begin
            r_mode     <= recirculate;
            r_byte_cnt <= '0;
         end
         if (w_out_valid && out_ready) begin
            r_byte_cnt <= r_byte_cnt + BCW'(1);
         end
         if (w_scan_en && w_last_bit) begin
            r_out_data <= w_rx_word;
         end
      end
   end

   assign w_load = (r_state == FETCH) && !abort && (r_mode || in_valid);

   scan_serdes #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_serdes (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_tx_data  (in_data),
      .i_shift    (w_scan_en),
      .i_recirc   (r_mode),
      .i_scan_out (mem_scan_out),
      .o_scan_in  (w_serdes_in),
      .o_last_bit (w_last_bit),
      .o_rx_word  (w_rx_word)
   );

   assign in_ready        = w_in_ready;
   assign out_valid       = w_out_valid;
   assign out_data        = r_out_data;
   assign mem_scan_enable = w_scan_en;
   // Held low outside shift cycles so the loopback path cannot leak onto the pin.
   assign mem_scan_in     = w_scan_en && w_serdes_in;
   assign busy            = w_busy;
   assign cpu_halt        = w_busy;
   assign done            = w_done;

endmodule

// File: tb/tb_mem_scan_loader.sv
// Bench for mem_scan_loader: a behavioural 256-bit chain stands in for the memory bank,
// and expected readback bytes are queued from the chain image at each pass start.
`timescale 1ns/1ps
module tb_mem_scan_loader;

   localparam int DW = 8;
   localparam int CL = 256;
   localparam int BC = CL / DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          recirculate = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   wire           in_ready;
   wire  [DW-1:0] out_data;
   wire           out_valid;
   wire           mem_scan_enable;
   wire           mem_scan_in;
   wire           mem_scan_out;
   wire           cpu_halt;
   wire           busy;
   wire           done;

   logic [CL-1:0] chain = '0;
   logic [DW-1:0] tx_bytes [BC];
   logic [DW-1:0] exp_q [$];
   int            err_cnt = 0;
   int            chk_cnt = 0;
   int            shift_total = 0;
   int            done_total = 0;
   int            pass_no = 0;

   always #5 clk = ~clk;

   mem_scan_loader dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .recirculate     (recirculate),
      .abort           (abort),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .out_data        (out_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .mem_scan_enable (mem_scan_enable),
      .mem_scan_in     (mem_scan_in),
      .mem_scan_out    (mem_scan_out),
      .cpu_halt        (cpu_halt),
      .busy            (busy),
      .done            (done)
   );

   // Memory bank chain: scan_in enters at bit 0, scan_out leaves from bit CL-1.
   assign mem_scan_out = chain[CL-1];
   always @(posedge clk) begin
      if (mem_scan_enable) chain <= {chain[CL-2:0], mem_scan_in};
   end

   always @(negedge clk) begin
      if (mem_scan_enable) shift_total++;
      if (done) done_total++;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // One full (or aborted) pass. stall_b/wait_b/abort_b select the byte to disturb (-1 = none).
   task automatic run_pass(input bit rc, input int stall_b, input int wait_b,
                           input int abort_b, input bit poke_start);
      logic [CL-1:0] snap;
      logic [DW-1:0] held;
      int fi, ei, sh, stall_n, wait_n, cyc, s0, d0;
      bit finished, aborted, poked;
      fi = 0; ei = 0; sh = 0; stall_n = 0; wait_n = 0; cyc = 0;
      finished = 0; aborted = 0; poked = 0; held = '0;
      pass_no++;
      @(negedge clk);
      snap = chain;
      s0 = shift_total;
      d0 = done_total;
      exp_q.delete();
      for (int k = 0; k < BC; k++) exp_q.push_back(snap[CL-1-DW*k -: DW]);
      start = 1'b1;
      recirculate = rc;
      @(posedge clk); #1;
      start = 1'b0;
      recirculate = 1'b0;
      check_val("busy_after_start", busy, 1);
      check_val("halt_after_start", cpu_halt, 1);
      check_val("in_ready_mode", in_ready, !rc);
      while (!finished && !aborted && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         out_ready = 1'b0;
         start = 1'b0;
         recirculate = 1'b0;
         if (done) begin
            finished = 1;
         end else if (abort_b >= 0 && mem_scan_enable && sh == abort_b * DW + 3) begin
            abort = 1'b1;
            #1;
            check_val("abort_gates_scan_en", mem_scan_enable, 0);
            aborted = 1;
         end else begin
            if (mem_scan_enable) sh++;
            if (poke_start && !poked && ei == 10) begin
               start = 1'b1;
               recirculate = !rc;
               poked = 1;
            end
            if (in_ready) begin
               if (fi == wait_b && wait_n < 4) begin
                  check_val("fetch_wait_no_shift", mem_scan_enable, 0);
                  wait_n++;
               end else begin
                  in_valid = 1'b1;
                  in_data = tx_bytes[fi];
                  fi++;
               end
            end
            if (out_valid) begin
               if (ei == stall_b && stall_n < 5) begin
                  if (stall_n == 0) held = out_data;
                  else check_val("stall_data_stable", out_data, held);
                  check_val("stall_scan_en", mem_scan_enable, 0);
                  stall_n++;
               end else begin
                  out_ready = 1'b1;
                  if (exp_q.size() == 0) check_val("readback_extra", 1, 0);
                  else check_val($sformatf("readback[%0d]", ei), out_data, exp_q.pop_front());
                  ei++;
               end
            end
         end
      end
      if (aborted) begin
         @(posedge clk); #1;
         abort = 1'b0;
         check_val("abort_busy", busy, 0);
         check_val("abort_halt", cpu_halt, 0);
         check_val("abort_out_valid", out_valid, 0);
         check_val("abort_in_ready", in_ready, 0);
         repeat (3) @(posedge clk);
         #1;
         check_val("abort_no_done", done_total - d0, 0);
         $display("pass %0d: mode=%0d aborted after %0d shifts", pass_no, rc, sh);
      end else begin
         check_val("pass_finished", finished, 1);
         check_val("byte_count", ei, BC);
         check_val("shift_cycles", shift_total - s0, CL);
         check_val("finish_busy", busy, 0);
         check_val("finish_halt", cpu_halt, 0);
         for (int k = 0; k < BC; k++) begin
            check_val($sformatf("image_addr%0d", BC - 1 - k), chain[CL-1-DW*k -: DW],
                      rc ? snap[CL-1-DW*k -: DW] : tx_bytes[k]);
         end
         @(posedge clk); #1;
         check_val("done_one_cycle", done, 0);
         check_val("done_pulses", done_total - d0, 1);
         $display("pass %0d: mode=%0d bytes=%0d shifts=%0d cycles=%0d", pass_no, rc, ei, shift_total - s0, cyc);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_val("rst_in_ready", in_ready, 0);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_data", out_data, 0);
      check_val("rst_scan_en", mem_scan_enable, 0);
      check_val("rst_scan_in", mem_scan_in, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_halt", cpu_halt, 0);
      check_val("rst_done", done, 0);

      for (int k = 0; k < BC; k++) tx_bytes[k] = DW'(k);
      run_pass(0, -1, -1, -1, 0);   // load 0x00..0x1F into an all-zero chain
      run_pass(1, -1, -1, -1, 0);   // dump: 0x00..0x1F
      run_pass(1, 3, -1, -1, 1);    // dump again with EMIT stall and a stray start
      for (int k = 0; k < BC; k++) tx_bytes[k] = DW'($urandom_range(0, 255));
      run_pass(0, -1, 2, -1, 0);    // load with in_valid held low in FETCH
      run_pass(0, -1, -1, 5, 0);    // abort in SHIFT of byte 5
      for (int k = 0; k < BC; k++) tx_bytes[k] = DW'($urandom_range(0, 255));
      run_pass(0, -1, -1, -1, 0);   // fresh full pass after abort
      run_pass(1, -1, -1, -1, 0);

      // Reset asserted between clock edges while shifting
      @(negedge clk);
      start = 1'b1;
      recirculate = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'hA5;
      for (int i = 0; i < 20 && !mem_scan_enable; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_val("reach_shift", mem_scan_enable, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_scan_en", mem_scan_enable, 0);
      check_val("async_rst_busy", busy, 0);
      check_val("async_rst_scan_in", mem_scan_in, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("post_rst_done", done, 0);
      check_val("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/mem_scan_loader.md
Name: mem_scan_loader

Overview:
- Sequences the memory bank's serial scan chain: 31 data cells, then the button bit, then the 7-bit LED register, 256 bits in total.
- Streams bytes from a host/programming port into the chain and, in the same pass, captures the bits falling out of the chain as readback bytes.
- A recirculate mode dumps the chain non-destructively.
- Holds the CPU halted while the chain is in motion.
- Sits between the top-level programming pins and the memory bank's scan_enable/scan_in/scan_out.

Parameters:
- DATA_WIDTH, 8: bits per transferred byte.
- CHAIN_LEN, 256: total scan-chain length in bits; must be a multiple of DATA_WIDTH.
- BYTE_CNT, CHAIN_LEN/DATA_WIDTH (32): bytes per full pass; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- recirculate  in  1  mode select, sampled with start; 1 = dump and restore, 0 = load from in_data
- abort  in  1  synchronous cancel of the current pass
- in_data  in  DATA_WIDTH  load byte
- in_valid  in  1  in_data valid
- in_ready  out  1  controller accepts in_data this cycle
- out_data  out  DATA_WIDTH  captured readback byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- mem_scan_enable  out  1  drives the memory bank scan_enable
- mem_scan_in  out  1  drives the memory bank scan_in
- mem_scan_out  in  1  from the memory bank scan_out
- cpu_halt  out  1  CPU stall request; equals busy
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at successful pass completion

Behaviour:
- Reset (rst_n low, async): state=IDLE. All outputs 0: in_ready, out_valid, out_data, mem_scan_enable, mem_scan_in, busy, cpu_halt, done. Bit and byte counters = 0. mem_scan_enable must drop immediately, not on the next edge.
- Reset mid-pass: chain contents are undefined afterwards; no done pulse.
- States: IDLE, FETCH, SHIFT, EMIT, FINISH.
- IDLE:
  - start=1 -> FETCH; latch recirculate into mode; byte_cnt=0; busy=1 from the next cycle.
  - start while not IDLE is ignored.
- FETCH:
  - Load mode: in_ready=1. On in_valid&in_ready, latch in_data into tx_reg and go to SHIFT. Stays in FETCH while in_valid=0.
  - Recirculate mode: no handshake; in_ready stays 0; go to SHIFT the next cycle.
- SHIFT (exactly DATA_WIDTH cycles, bit_cnt 0..7):
  - mem_scan_enable=1 on each of these cycles and on no other cycle.
  - mem_scan_in: load mode = tx_reg[DATA_WIDTH-1-bit_cnt] (MSB first); recirculate mode = mem_scan_out (combinational loopback).
  - On each edge, rx_reg = {rx_reg[DATA_WIDTH-2:0], mem_scan_out}, sampled before the chain shifts. The first sampled bit lands in out_data bit 7.
  - After bit_cnt=7: out_data=rx_reg, then EMIT.
- EMIT:
  - out_valid=1 and out_data stable until out_ready.
  - On handshake, byte_cnt+1. If byte_cnt was BYTE_CNT-1 -> FINISH, else FETCH.
  - While stalled, mem_scan_enable=0 and the chain holds.
- FINISH: one cycle; done=1, busy=0, cpu_halt=0; then IDLE.
- Throughput with no stalls: 10 cycles per byte (FETCH 1, SHIFT 8, EMIT 1); full pass 320 cycles plus FINISH.
- Data ordering:
  - Load: byte k of the input stream is the k-th byte pushed in; after a full pass, input byte 0 occupies the chain end farthest from scan_in.
  - Readback: byte k is the k-th byte to exit the chain.
  - Consequence: a full recirculate pass leaves the chain contents unchanged, and a second dump equals the first.
- abort=1 in any non-IDLE state:
  - Next state IDLE; mem_scan_enable=0 that cycle.
  - out_valid and in_ready drop; no done pulse; partially shifted chain is left as-is.
  - abort has priority over a simultaneous in_valid or out_ready handshake.
- Counters: bit_cnt is 3 bits; byte_cnt is $clog2(BYTE_CNT)+1 bits, no wrap past BYTE_CNT.

Decomposition:
- Package mem_scan_pkg:
  - state enum {IDLE, FETCH, SHIFT, EMIT, FINISH}
  - localparams SCAN_DATA_WIDTH=8, SCAN_CHAIN_LEN=256
- Sub-module scan_serdes: tx_reg/rx_reg, bit counter, MSB-first serialise/deserialise and the recirculate mux, with load/shift/last-bit strobes.
- The FSM, handshakes and byte counter stay in mem_scan_loader.

Test Plan:
- Reset, then idle 5 cycles -> every output 0. Assert rst_n low mid-SHIFT -> mem_scan_enable falls with no clock edge.
- From reset (chain all zero), load pass with bytes 0x00..0x1F, out_ready=1 -> 32 readback bytes all 0x00, 256 mem_scan_enable cycles, done one cycle, chain matches bank data_out 0x1F..0x00 at addresses 0..31 per the defined ordering.
- Recirculate pass after the load -> readback 0x00..0x1F. A second recirculate pass returns identical bytes; memory read values unchanged.
- out_ready low 5 cycles in EMIT of byte 3 -> out_data stable, mem_scan_enable 0, total shift cycles still 256, readback unchanged.
- in_valid low 4 cycles in FETCH -> in_ready held 1, no shifting. Pulse start mid-pass -> ignored, byte count unaffected.
- abort in SHIFT of byte 5 -> IDLE the next cycle, busy/cpu_halt 0, no done. A fresh start then runs a full 32-byte pass.
